// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider answering the EXE divide handshake; WIDTH iterations per request.
// Define ITER_DIV_EARLY_EXIT_EN to skip the dividend's leading zeros (same results, shorter latency).
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               s1_neg_q, s1_neg_d;
  logic               q_neg_q, q_neg_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   raw1_q, raw1_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH-1:0] prem_init;
  logic [CW-1:0]      cnt_init;
  logic [2*WIDTH-1:0] shifted, step;
  logic [WIDTH:0]     diff;
  logic               take;
  logic [WIDTH-1:0]   q_mag, r_mag;

  assign abs1 = (div_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign abs2 = (div_signed && src2[WIDTH-1]) ? -src2 : src2;

`ifdef ITER_DIV_EARLY_EXIT_EN
  function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
    lzc = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) lzc = CW'(WIDTH - 1 - i);
    end
  endfunction

  logic [CW-1:0] lz;
  assign lz        = lzc(abs1);
  assign prem_init = {{WIDTH{1'b0}}, abs1} << lz;
  // A zero dividend still runs one iteration so DONE is always reached via BUSY.
  assign cnt_init  = (lz == CW'(WIDTH)) ? CNT_ONE : CW'(WIDTH) - lz;
`else
  assign prem_init = {{WIDTH{1'b0}}, abs1};
  assign cnt_init  = CW'(WIDTH);
`endif

  // The carry out of the shifted upper half means it already exceeds any WIDTH-bit divisor.
  assign shifted = {prem_q[2*WIDTH-2:0], 1'b0};
  assign diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dvsr_q};
  assign take    = prem_q[2*WIDTH-1] | ~diff[WIDTH];
  assign step    = take ? {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1} : shifted;
  assign q_mag   = step[WIDTH-1:0];
  assign r_mag   = step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    prem_d   = prem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    s1_neg_d = s1_neg_q;
    q_neg_d  = q_neg_q;
    dbz_d    = dbz_q;
    raw1_d   = raw1_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d  = BUSY;
            prem_d   = prem_init;
            dvsr_d   = abs2;
            cnt_d    = cnt_init;
            sgn_d    = div_signed;
            s1_neg_d = src1[WIDTH-1];
            q_neg_d  = src1[WIDTH-1] ^ src2[WIDTH-1];
            dbz_d    = (src2 == '0);
            raw1_d   = src1;
          end
        end
        BUSY: begin
          prem_d = step;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
            if (dbz_q) begin
              quo_d = '1;
              rem_d = raw1_q;
            end else begin
              quo_d = (sgn_q && q_neg_q) ? -q_mag : q_mag;
              rem_d = (sgn_q && s1_neg_q) ? -r_mag : r_mag;
            end
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prem_q   <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      s1_neg_q <= 1'b0;
      q_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
      raw1_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      prem_q   <= prem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      s1_neg_q <= s1_neg_d;
      q_neg_q  <= q_neg_d;
      dbz_q    <= dbz_d;
      raw1_q   <= raw1_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Iterative radix-2 restoring divider; the responder side of the EXE-stage divide handshake (in_valid/in_ready request, out_valid/out_ready response).
- Computes quotient and remainder for signed or unsigned operands over WIDTH-bit data.
- Serves div.w/div.wu/mod.w/mod.wu. EXE holds its pipeline until out_valid is seen.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: request valid; operands are sampled on accept.
- in_ready, output, 1: unit idle and able to accept a request.
- div_signed, input, 1: 1 = two's-complement signed divide; 0 = unsigned divide.
- flush, input, 1: synchronous abort of any request in flight.
- src1, input, WIDTH: dividend.
- src2, input, WIDTH: divisor.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, WIDTH: quotient result.
- remainder, output, WIDTH: remainder result.

Behaviour:
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Reset:
  - state goes to IDLE.
  - out_valid = 0, in_ready = 1 from the first cycle after reset.
  - quotient = 0, remainder = 0, iteration counter = 0.
- Accept:
  - Occurs on a rising edge with state == IDLE, in_valid = 1 and flush = 0; this is edge E0.
  - Latch |src1|, |src2|, the sign of src1, the sign of the quotient, the div_signed flag, the divide-by-zero flag, and the raw src1. Move to BUSY.
  - Absolute values are taken only when div_signed = 1. The magnitude of 0x80000000 is the unsigned value 0x80000000.
- BUSY:
  - One iteration per edge, using a (2*WIDTH)-bit partial remainder register.
  - Each iteration: shift left by 1; trial-subtract the divisor from the upper half; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
  - A WIDTH-iteration counter runs from edge E1 through edge E_WIDTH.
  - On the edge that completes the last iteration, move to DONE and load the quotient/remainder output registers. out_valid rises after E_WIDTH, which is cycle WIDTH+1 counting the accept cycle as 0 (cycle 33 for WIDTH = 32).
- Sign fix-up, applied when loading the outputs:
  - quotient is negated if the quotient sign is set.
  - remainder takes the sign of the dividend (truncating division).
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0, with no special handling.
- Divide by zero: src2 == 0 runs the normal latency; the result is forced to quotient = all ones and remainder = raw src1, for both signed and unsigned.
- DONE:
  - quotient and remainder stay stable while out_valid = 1 and out_ready = 0.
  - On out_ready = 1, move to IDLE; out_valid = 0 on the next cycle. No same-cycle re-accept: in_ready is low in DONE.
- Flush:
  - Takes priority over every other event. From any state the unit goes to IDLE on the next edge with out_valid = 0.
  - A pending result is discarded.
  - flush together with in_valid in IDLE means no accept.
- Operands are ignored outside the accept edge. in_valid held high while BUSY has no effect.

Optional Feature:
- Macro: ITER_DIV_EARLY_EXIT_EN.
- Defined:
  - At accept, compute lz = leading-zero count of |src1|.
  - Pre-shift the partial remainder left by lz and load the counter with WIDTH - lz, so BUSY lasts max(WIDTH - lz, 1) iterations.
  - A dividend of 0 takes 1 iteration.
  - Results are identical to the undefined case; only latency changes.
- Undefined: latency is fixed at WIDTH iterations; no leading-zero logic is built.

Test Plan:
1. Unsigned 100 / 7 with div_signed = 0 -> quotient = 14, remainder = 2; out_valid rises at cycle 33 after accept. With ITER_DIV_EARLY_EXIT_EN defined: 7 iterations, out_valid at cycle 8.
2. Signed cases:
   - -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
   - 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
   - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
3. Divide by zero: 5 / 0, both signed and unsigned -> quotient 0xFFFFFFFF, remainder 5. Signed 0xFFFFFFF9 / 0 -> remainder 0xFFFFFFF9.
4. Flush:
   - Assert flush at cycle 10 of BUSY -> out_valid never rises; in_ready = 1 next cycle.
   - A new 9 / 3 request then yields quotient 3, remainder 0.
5. Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> quotient/remainder stable, in_ready = 0 throughout. Raise out_ready -> IDLE next cycle.
6. Reset during BUSY -> out_valid = 0, in_ready = 1, outputs = 0 next cycle. A flush/in_valid collision in IDLE -> no accept.
